dc_token_ring_writer: RTL and testbench



---
 rtl/dc_fifo_pkg.sv | 29 ++
 rtl/dc_token_sync.sv | 57 +++++
 rtl/dc_token_ring_writer.sv | 72 +++++++
 tb/tb_dc_token_ring_writer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dc_fifo_pkg.sv
// Shared types and helpers for the dual-clock token-ring buffer controllers.
// Token vectors are passed zero-extended to MAX_TOKEN_WIDTH so the helpers stay width-generic.
package dc_fifo_pkg;

    localparam int unsigned DEFAULT_BUFFER_DEPTH = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES  = 2;
    localparam int unsigned MAX_TOKEN_WIDTH      = 64;
    localparam int unsigned TOKEN_IDX_W          = $clog2(MAX_TOKEN_WIDTH);

    // Rotate the low 'width' bits of v left by one; bit width-1 wraps to bit 0.
    function automatic logic [MAX_TOKEN_WIDTH-1:0] rotl_onehot(
        input logic [MAX_TOKEN_WIDTH-1:0] v,
        input int unsigned                width
    );
        logic [MAX_TOKEN_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_TOKEN_WIDTH; i++) begin
            if (i < width) begin
                r[TOKEN_IDX_W'((i + 1) % width)] = v[i];
            end
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MAX_TOKEN_WIDTH-1:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/dc_token_sync.sv
// Multi-flop synchronizer for a one-hot token, followed by a hold register that
// only accepts exactly-one-hot captures so a mid-move sample never escapes.
module dc_token_sync
    import dc_fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_BUFFER_DEPTH,
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("dc_token_sync: STAGES must be at least 2");
        end
        if (WIDTH < 2 || WIDTH > MAX_TOKEN_WIDTH) begin : g_bad_width
            $error("dc_token_sync: WIDTH out of range");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] hold_q;
    logic             last_onehot;

    assign last_onehot = is_onehot(MAX_TOKEN_WIDTH'(stage_q[STAGES-1]));

    // Raw capture chain; the first stage may go metastable on async_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= WIDTH'(1);
            end
        end else begin
            stage_q[0] <= async_in;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // A stale token only makes the consumer more conservative, so holding is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= WIDTH'(1);
        end else if (last_onehot) begin
            hold_q <= stage_q[STAGES-1];
        end
    end

    assign sync_out = hold_q;

    a_hold_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(hold_q));

endmodule

// File: rtl/dc_token_ring_writer.sv
// Source-domain write controller: owns the one-hot write token ring and derives
// full from the synchronized read token; the buffer write path is same-cycle.
module dc_token_ring_writer
    import dc_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
    parameter int unsigned SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    ready_out,
    input  logic [BUFFER_DEPTH-1:0] read_token,
    output logic [BUFFER_DEPTH-1:0] write_pointer,
    output logic                    write_enable,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic                    full
);

    generate
        if (BUFFER_DEPTH < 2) begin : g_bad_depth
            $error("dc_token_ring_writer: BUFFER_DEPTH must be at least 2");
        end
    endgenerate

    logic [BUFFER_DEPTH-1:0] wp_q;
    logic [BUFFER_DEPTH-1:0] wp_next;
    logic [BUFFER_DEPTH-1:0] wp_rotl;
    logic [BUFFER_DEPTH-1:0] rd_q;
    logic                    xfer;

    dc_token_sync #(
        .WIDTH  (BUFFER_DEPTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (read_token),
        .sync_out (rd_q)
    );

    assign wp_rotl = BUFFER_DEPTH'(rotl_onehot(MAX_TOKEN_WIDTH'(wp_q), BUFFER_DEPTH));

    // One slot is sacrificed so that equal tokens unambiguously mean empty.
    assign full      = (wp_rotl == rd_q);
    assign ready_out = !full && !rst;
    assign xfer      = valid_in && ready_out;

    assign write_enable  = xfer;
    assign write_data    = data_in;
    assign write_pointer = wp_q;

    always_comb begin
        wp_next = wp_q;
        if (xfer) begin
            wp_next = wp_rotl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= BUFFER_DEPTH'(1);
        end else begin
            wp_q <= wp_next;
        end
    end

    a_wp_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(wp_q));

endmodule

// File: tb/tb_dc_token_ring_writer.sv
// Directed bench for dc_token_ring_writer: expected buffer writes go into a
// scoreboard queue and a negedge monitor checks every write strobe against it.
module tb_dc_token_ring_writer;

    localparam int unsigned DW = 32;
    localparam int unsigned BD = 8;
    localparam int unsigned SS = 2;

    typedef struct packed {
        logic [BD-1:0] ptr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ready_out;
    logic [BD-1:0] read_token = 8'h01;
    logic [BD-1:0] write_pointer;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          full;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    dc_token_ring_writer #(
        .DATA_WIDTH   (DW),
        .BUFFER_DEPTH (BD),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ready_out     (ready_out),
        .read_token    (read_token),
        .write_pointer (write_pointer),
        .write_enable  (write_enable),
        .write_data    (write_data),
        .full          (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [BD-1:0] ptr, input logic [DW-1:0] data);
        wr_t e;
        e.ptr  = ptr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: ptr %h data %h, no write expected at %0t",
                         write_pointer, write_data, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_ptr", 32'(write_pointer), 32'(e.ptr));
                check("wr_data", write_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset
        #1 rst = 1'b1;
        #2;
        check("rst_wp", 32'(write_pointer), 32'h01);
        check("rst_ready", 32'(ready_out), 32'h0);
        check("rst_we", 32'(write_enable), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("post_rst_wp", 32'(write_pointer), 32'h01);
        check("post_rst_ready", 32'(ready_out), 32'h1);
        check("post_rst_full", 32'(full), 32'h0);
        check("post_rst_we", 32'(write_enable), 32'h0);
        tick();

        // Seven back-to-back writes fill the usable capacity
        for (int i = 0; i < 7; i++) begin
            expect_write(BD'(8'h01 << i), DW'(32'hA0 + i));
            valid_in = 1'b1;
            data_in  = DW'(32'hA0 + i);
            tick();
        end
        check("fill_wp", 32'(write_pointer), 32'h80);
        check("fill_full", 32'(full), 32'h1);
        check("fill_ready", 32'(ready_out), 32'h0);

        // Stall while full with valid held high
        data_in = 32'hBB;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_wp", 32'(write_pointer), 32'h80);
            check("stall_full", 32'(full), 32'h1);
        end
        valid_in = 1'b0;

        // Reader advances: full clears on the third edge
        read_token = 8'h02;
        tick();
        check("sync_e1_full", 32'(full), 32'h1);
        tick();
        check("sync_e2_full", 32'(full), 32'h1);
        tick();
        check("sync_e3_full", 32'(full), 32'h0);
        check("sync_e3_ready", 32'(ready_out), 32'h1);

        expect_write(8'h80, 32'hC0);
        valid_in = 1'b1;
        data_in  = 32'hC0;
        tick();
        valid_in = 1'b0;
        check("wrap_wp", 32'(write_pointer), 32'h01);
        check("wrap_full", 32'(full), 32'h1);

        // Two-hot token during a move must never be accepted
        read_token = 8'h03;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("twohot_full", 32'(full), 32'h1);
            check("twohot_rdq", 32'(dut.u_sync.sync_out), 32'h02);
        end
        read_token = 8'h02;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("settle_full", 32'(full), 32'h1);
            check("settle_ready", 32'(ready_out), 32'h0);
        end
        check("settle_rdq", 32'(dut.u_sync.sync_out), 32'h02);

        // Reader catches up to empty, then four writes bring wp to 0x10
        read_token = 8'h01;
        repeat (3) tick();
        check("empty_full", 32'(full), 32'h0);
        for (int i = 0; i < 4; i++) begin
            expect_write(BD'(8'h01 << i), DW'(32'hD0 + i));
            valid_in = 1'b1;
            data_in  = DW'(32'hD0 + i);
            tick();
        end
        check("burst_wp", 32'(write_pointer), 32'h10);

        // Asynchronous reset mid-burst drops the in-flight write
        data_in = 32'hD4;
        #2 rst = 1'b1;
        #1;
        check("midrst_wp", 32'(write_pointer), 32'h01);
        check("midrst_we", 32'(write_enable), 32'h0);
        check("midrst_ready", 32'(ready_out), 32'h0);
        valid_in = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(ready_out), 32'h1);
        check("rel_full", 32'(full), 32'h0);
        tick();
        expect_write(8'h01, 32'hE0);
        valid_in = 1'b1;
        data_in  = 32'hE0;
        tick();
        valid_in = 1'b0;
        check("after_rst_wp", 32'(write_pointer), 32'h02);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
